out_port_unit: RTL
==================

OUT_PORT_UNIT -- requirements
Module: out_port_unit

Interface
REQ-001 Parameter WIDTH, 32, data word width; matches bus width.
REQ-002 Parameter DEPTH, 4, FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 BusMuxOut  input  WIDTH  CPU bus value to be written out.
REQ-006 OutPortIn  input  1  CPU write strobe; one word captured per high cycle.
REQ-007 OutPortLatched  output  WIDTH  last word accepted from the bus (architectural out-port register).
REQ-008 OutPortFull  output  1  FIFO holds DEPTH words.
REQ-009 OutPortEmpty  output  1  FIFO holds zero words.
REQ-010 OutPortCount  output  $clog2(DEPTH)+1  current occupancy.
REQ-011 OutPortOvf  output  1  sticky: a write was dropped.
REQ-012 dev_data  output  WIDTH  word offered to the external device.
REQ-013 dev_valid  output  1  dev_data is valid.
REQ-014 dev_ready  input  1  device accepts dev_data this cycle.

Function
REQ-015 Write accepted when OutPortIn=1 AND (count<DEPTH OR pop this cycle); word stored at tail, tail pointer advances modulo DEPTH.
REQ-016 Accepted write updates OutPortLatched to BusMuxOut on the same edge; dropped write leaves OutPortLatched, FIFO and count unchanged and sets OutPortOvf.
REQ-017 Pop occurs when dev_valid=1 AND dev_ready=1; head pointer advances modulo DEPTH.
REQ-018 dev_valid = !OutPortEmpty; dev_data = FIFO head entry, both registered-state derived (no combinational path from BusMuxOut or dev_ready).
REQ-019 No bypass: word written to empty FIFO at edge N appears with dev_valid=1 after edge N; earliest pop at edge N+1.
REQ-020 While dev_valid=1 and dev_ready=0, dev_data and dev_valid hold stable.
REQ-021 Simultaneous write and pop: count unchanged; when full, both succeed, no overflow.
REQ-022 Count: +1 on write-only, -1 on pop-only, unchanged otherwise; never exceeds DEPTH, never below 0.
REQ-023 Words leave in acceptance order; none duplicated or lost except REQ-016 drops.
REQ-024 OutPortFull = (count==DEPTH); OutPortEmpty = (count==0); derived from registered count.
REQ-025 dev_ready while empty has no effect.

Reset
REQ-026 clr=0 immediately forces: pointers 0, count 0, OutPortLatched 0, OutPortOvf 0, dev_valid 0, OutPortEmpty 1, OutPortFull 0.
REQ-027 Reset mid-transfer discards all queued words; no pop is reported for the cycle in which clr is low.
REQ-028 First write accepted on first rising edge with clr=1; OutPortOvf clears only by reset.
REQ-029 FIFO storage array need not be reset; dev_data is don't-care while dev_valid=0.

Structure
REQ-030 WIDTH default and word type live in shared package cpu_pkg.
REQ-031 One sub-module out_fifo (storage, pointers, count); out_port_unit adds OutPortLatched, overflow flag, device handshake.

Verification
REQ-032 Reset, write 0x0000000F, dev_ready=1 -> next cycle dev_valid=1, dev_data=0x0000000F, OutPortLatched=0x0000000F; following cycle empty.
REQ-033 dev_ready=0, write 1,2,3,4,5 -> Full after 4th, 5th dropped, OutPortOvf=1, OutPortLatched=4, count=4; then ready=1 drains 1,2,3,4 in order.
REQ-034 Full FIFO, OutPortIn=1 with value 9 and dev_ready=1 same cycle -> pop of head, 9 accepted, count stays 4, OutPortOvf=0.
REQ-035 dev_valid=1, dev_ready toggled 0/1 randomly over 20 writes -> dev_data stable during stalls, sequence matches write order.
REQ-036 Three words queued, clr pulsed low mid-cycle -> dev_valid=0, count=0, OutPortLatched=0 immediately (asynchronous), no word output after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: bus word width and word type.
package cpu_pkg;

  localparam int unsigned WIDTH = 32;

  typedef logic [WIDTH-1:0] word_t;

endpackage : cpu_pkg

// File: rtl/out_port_unit_if.sv
// Device-side valid/ready handshake of the out-port unit.
//   dev_data  : word offered to the external device
//   dev_valid : dev_data holds a queued word
//   dev_ready : device takes dev_data on this rising edge
// master = the out-port unit (source), slave = the external device (sink).
interface out_port_unit_if #(
  parameter int unsigned WIDTH = cpu_pkg::WIDTH
);

  logic [WIDTH-1:0] dev_data;
  logic             dev_valid;
  logic             dev_ready;

  modport master (output dev_data, output dev_valid, input dev_ready);
  modport slave  (input dev_data, input dev_valid, output dev_ready);

endinterface : out_port_unit_if

// File: rtl/out_fifo.sv
// Circular FIFO: storage, head/tail pointers and occupancy count.
// Ports:
//   clk, clr        : clock, async active-low reset
//   wr_en, wr_data  : push (caller guarantees room, or a same-cycle pop)
//   rd_en           : pop (caller guarantees not empty)
//   rd_data         : head entry, taken from registered state only
//   count/full/empty: registered occupancy and its flags
module out_fifo #(
  parameter int unsigned WIDTH = cpu_pkg::WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count_nxt;

  // Occupancy update; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = count;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (wr_en) tail <= tail + PW'(1);
      if (rd_en) head <= head + PW'(1);
      count <= count_nxt;
      empty <= (count_nxt == CW'(0));
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  // Storage is intentionally not reset; contents only matter behind count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[tail] <= wr_data;
  end

  assign rd_data = mem[head];

endmodule : out_fifo

// File: rtl/out_port_unit.sv
// CPU output port: latches bus writes into the architectural out-port
// register and queues them in a FIFO drained by an external device.
// Ports:
//   clk, clr        : clock, async active-low reset
//   BusMuxOut       : CPU bus value
//   OutPortIn       : CPU write strobe, one word per high cycle
//   OutPortLatched  : last accepted word
//   OutPortFull/Empty/Count : FIFO status
//   OutPortOvf      : sticky, set when a write is dropped on a full FIFO
//   dev             : device handshake (master side)
module out_port_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = cpu_pkg::WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [WIDTH-1:0]       BusMuxOut,
  input  logic                   OutPortIn,
  output logic [WIDTH-1:0]       OutPortLatched,
  output logic                   OutPortFull,
  output logic                   OutPortEmpty,
  output logic [$clog2(DEPTH):0] OutPortCount,
  output logic                   OutPortOvf,
  out_port_unit_if.master        dev
);

  logic             pop_c;
  logic             accept_c;
  logic [WIDTH-1:0] head_data;

  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign pop_c    = !OutPortEmpty && dev.dev_ready;
  assign accept_c = OutPortIn && (!OutPortFull || pop_c);

  out_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .wr_en   (accept_c),
    .wr_data (BusMuxOut),
    .rd_en   (pop_c),
    .rd_data (head_data),
    .count   (OutPortCount),
    .full    (OutPortFull),
    .empty   (OutPortEmpty)
  );

  // Architectural out-port register and sticky drop flag.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      OutPortLatched <= '0;
      OutPortOvf     <= 1'b0;
    end else begin
      if (accept_c) OutPortLatched <= BusMuxOut;
      if (OutPortIn && !accept_c) OutPortOvf <= 1'b1;
    end
  end

  // Device side is driven purely from FIFO state: no bypass from the bus.
  assign dev.dev_valid = !OutPortEmpty;
  assign dev.dev_data  = head_data;

endmodule : out_port_unit
